// File: rtl/irq_vector_dispatch.sv
// Queues encoded interrupt vectors, pops one when idle (1 edge after accept), acks it for one cycle, holds it until eoi.
// req_ready drops when the queue holds DEPTH vectors; a request while not ready is lost and flags err.
module irq_vector_dispatch #(
   parameter int NCH   = 9,
   parameter int IDW   = 4,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   input  logic [IDW-1:0]           req_id,
   output logic                     req_ready,
   output logic [NCH-1:0]           ack,
   output logic                     isr_busy,
   output logic [IDW-1:0]           isr_id,
   input  logic                     eoi,
   output logic [$clog2(DEPTH):0]   pend_cnt,
   output logic [NCH-1:0]           pend_mask,
   output logic                     err,
   input  logic                     clr_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ACK     = 2'd1;
   localparam logic [1:0] S_SERVICE = 2'd2;

   logic [1:0]     state;
   logic [IDW-1:0] mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [NCH-1:0] req_oh;
   logic [NCH-1:0] head_oh;
   logic [NCH-1:0] isr_oh;
   logic           xfer;
   logic           push;
   logic           pop;
   logic           done;
   logic           err_set;

   // An out-of-range id decodes to all-zero, which doubles as the range check.
   always_comb begin
      req_oh  = '0;
      head_oh = '0;
      isr_oh  = '0;
      for (int i = 0; i < NCH; i++) begin
         if (req_id == IDW'(i))      req_oh[i]  = 1'b1;
         if (mem[rd_ptr] == IDW'(i)) head_oh[i] = 1'b1;
         if (isr_id == IDW'(i))      isr_oh[i]  = 1'b1;
      end
   end

   assign req_ready = (pend_cnt != CW'(DEPTH));
   assign xfer      = req_valid && req_ready;
   // The in-service id stays in pend_mask, so a push racing its eoi is a duplicate.
   assign push      = xfer && (|req_oh) && !(|(req_oh & pend_mask));
   assign pop       = (state == S_IDLE) && (pend_cnt != '0);
   assign done      = (state == S_SERVICE) && eoi;
   assign err_set   = (req_valid && !req_ready) || (xfer && !(|req_oh));

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= req_id;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         pend_cnt  <= '0;
         pend_mask <= '0;
         state     <= S_IDLE;
         ack       <= '0;
         isr_busy  <= 1'b0;
         isr_id    <= '0;
         err       <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         pend_cnt  <= pend_cnt + CW'(push) - CW'(pop);
         pend_mask <= (pend_mask & ~(done ? isr_oh : '0)) | (push ? req_oh : '0);
         ack       <= '0;

         case (state)
            S_IDLE: begin
               if (pop) begin
                  state    <= S_ACK;
                  isr_id   <= mem[rd_ptr];
                  ack      <= head_oh;
                  isr_busy <= 1'b1;
               end
            end
            S_ACK: begin
               state <= S_SERVICE;
            end
            S_SERVICE: begin
               if (eoi) begin
                  state    <= S_IDLE;
                  isr_id   <= '0;
                  isr_busy <= 1'b0;
               end
            end
            default: begin
               state    <= S_IDLE;
               isr_id   <= '0;
               isr_busy <= 1'b0;
            end
         endcase

         if (err_set)      err <= 1'b1;
         else if (clr_err) err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_irq_vector_dispatch.sv
// Bench for irq_vector_dispatch: queue-based reference model plus directed literal checks and random traffic.
module tb_irq_vector_dispatch;

   localparam int NCH   = 9;
   localparam int IDW   = 4;
   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           req_valid = 1'b0;
   logic [IDW-1:0] req_id = '0;
   logic           eoi = 1'b0;
   logic           clr_err = 1'b0;
   logic           req_ready;
   logic [NCH-1:0] ack;
   logic           isr_busy;
   logic [IDW-1:0] isr_id;
   logic [CW-1:0]  pend_cnt;
   logic [NCH-1:0] pend_mask;
   logic           err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   irq_vector_dispatch #(.NCH(NCH), .IDW(IDW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_id    (req_id),
      .req_ready (req_ready),
      .ack       (ack),
      .isr_busy  (isr_busy),
      .isr_id    (isr_id),
      .eoi       (eoi),
      .pend_cnt  (pend_cnt),
      .pend_mask (pend_mask),
      .err       (err),
      .clr_err   (clr_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pending queue, per-channel pending flags, current
   // service id (-1 when idle) and whether this is the ack cycle.
   int             q[$];
   logic [NCH-1:0] m_mask;
   int             cur = -1;
   bit             in_ack = 0;
   bit             m_err = 0;
   bit             live = 0;
   bit             m_full, m_es, m_can_pop, m_end;
   int             m_id;

   always begin
      @(posedge clk);
      if (rst) begin
         q.delete();
         m_mask = '0;
         cur    = -1;
         in_ack = 0;
         m_err  = 0;
         live   = 1;
      end else if (live) begin
         m_full    = (q.size() == DEPTH);
         m_can_pop = (cur < 0) && (q.size() > 0);
         m_end     = (cur >= 0) && !in_ack && eoi;
         m_es      = 0;
         m_id      = int'(req_id);
         if (req_valid) begin
            if (m_full)                m_es = 1;
            else if (m_id >= NCH)      m_es = 1;
            else if (!m_mask[m_id]) begin
               q.push_back(m_id);
               m_mask[m_id] = 1'b1;
            end
         end
         if (m_can_pop) begin
            cur    = q.pop_front();
            in_ack = 1;
         end else if (in_ack) begin
            in_ack = 0;
         end else if (m_end) begin
            m_mask[cur] = 1'b0;
            cur         = -1;
         end
         if (m_es)         m_err = 1;
         else if (clr_err) m_err = 0;
      end
   end

   logic [NCH-1:0] e_ack;
   always begin
      @(negedge clk);
      if (live) begin
         e_ack = '0;
         if (in_ack) e_ack[cur] = 1'b1;
         chk("m_ack",       ack,       e_ack);
         chk("m_isr_busy",  isr_busy,  cur >= 0);
         chk("m_isr_id",    isr_id,    (cur >= 0) ? cur : 0);
         chk("m_pend_cnt",  pend_cnt,  q.size());
         chk("m_pend_mask", pend_mask, m_mask);
         chk("m_err",       err,       m_err);
         chk("m_req_ready", req_ready, q.size() != DEPTH);
      end
   end

   task automatic step(input bit v, input int id, input bit e, input bit c, input bit r);
      req_valid = v;
      req_id    = IDW'(id);
      eoi       = e;
      clr_err   = c;
      rst       = r;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0);
   endtask

   int ids[4] = '{2, 7, 0, 8};

   initial begin
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      chk("rst_cnt",   pend_cnt,  0);
      chk("rst_mask",  pend_mask, 0);
      chk("rst_ack",   ack,       0);
      chk("rst_busy",  isr_busy,  0);
      chk("rst_isrid", isr_id,    0);
      chk("rst_err",   err,       0);
      chk("rst_ready", req_ready, 1);

      // single vector id 3
      step(1, 3, 0, 0, 0);
      chk("s3_cnt1",  pend_cnt, 1);
      chk("s3_noack", ack,      0);
      idle();
      chk("s3_ack",   ack,       9'b000001000);
      chk("s3_id",    isr_id,    3);
      chk("s3_busy",  isr_busy,  1);
      chk("s3_cnt0",  pend_cnt,  0);
      chk("s3_mask",  pend_mask, 9'h008);
      idle();
      chk("s3_ackoff", ack,      0);
      chk("s3_busy2",  isr_busy, 1);
      idle();
      step(0, 0, 1, 0, 0);
      chk("s3_eoi_busy", isr_busy,  0);
      chk("s3_eoi_mask", pend_mask, 0);
      chk("s3_eoi_id",   isr_id,    0);

      // fill queue behind id 1, overflow, clear, drain in order
      step(1, 1, 0, 0, 0);
      idle();
      idle();
      foreach (ids[k]) step(1, ids[k], 0, 0, 0);
      chk("fill_cnt",   pend_cnt,  4);
      chk("fill_ready", req_ready, 0);
      step(1, 4, 0, 0, 0);
      chk("ovf_err",  err,       1);
      chk("ovf_cnt",  pend_cnt,  4);
      chk("ovf_mask", pend_mask, 9'h187);
      step(0, 0, 0, 1, 0);
      chk("clr_err", err, 0);
      for (int k = 0; k < 4; k++) begin
         step(0, 0, 1, 0, 0);
         chk("ord_idle",  isr_busy, 0);
         chk("ord_cnt_a", pend_cnt, 4 - k);
         idle();
         chk("ord_ack",   ack,       9'(1) << ids[k]);
         chk("ord_cnt_b", pend_cnt,  3 - k);
         chk("ord_ready", req_ready, 1);
         idle();
      end
      step(0, 0, 1, 0, 0);
      chk("ord_fin_cnt",  pend_cnt,  0);
      chk("ord_fin_mask", pend_mask, 0);

      // duplicate and out-of-range ids
      step(1, 1, 0, 0, 0);
      idle();
      idle();
      step(1, 6, 0, 0, 0);
      chk("dup_cnt1", pend_cnt, 1);
      step(1, 6, 0, 0, 0);
      chk("dup_cnt", pend_cnt, 1);
      chk("dup_err", err,      0);
      step(1, 12, 0, 0, 0);
      chk("bad_err", err,      1);
      chk("bad_cnt", pend_cnt, 1);
      step(0, 0, 0, 1, 0);
      step(0, 0, 1, 0, 0);
      idle();
      idle();
      step(0, 0, 1, 0, 0);

      // eoi during ACK is ignored
      step(1, 1, 0, 0, 0);
      idle();
      chk("ea_ack", ack, 9'h002);
      step(0, 0, 1, 0, 0);
      chk("ea_busy", isr_busy, 1);
      chk("ea_ack0", ack,      0);
      idle();
      idle();
      chk("ea_busy2", isr_busy, 1);
      chk("ea_noack", ack,      0);
      step(0, 0, 1, 0, 0);
      chk("ea_done", isr_busy, 0);

      // same-cycle accept of X with eoi for X, then reset mid-service
      step(1, 5, 0, 0, 0);
      idle();
      idle();
      step(1, 5, 1, 0, 0);
      chk("sx_mask", pend_mask, 0);
      chk("sx_cnt",  pend_cnt,  0);
      chk("sx_busy", isr_busy,  0);
      step(1, 5, 0, 0, 0);
      chk("sx_again", pend_cnt, 1);
      idle();
      idle();
      step(1, 2, 0, 0, 0);
      step(1, 3, 0, 0, 0);
      step(1, 4, 0, 0, 0);
      chk("rs_pre_cnt", pend_cnt, 3);
      step(1, 15, 0, 0, 0);
      chk("rs_pre_err", err, 1);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      idle();
      chk("rs_ack",  ack,       0);
      chk("rs_busy", isr_busy,  0);
      chk("rs_cnt",  pend_cnt,  0);
      chk("rs_mask", pend_mask, 0);
      chk("rs_err",  err,       0);

      // random traffic, checked every cycle by the model
      for (int n = 0; n < 3000; n++) begin
         step($urandom_range(0, 9) < 6,
              ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, NCH - 1)),
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 19) == 0,
              $urandom_range(0, 199) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/irq_vector_dispatch.md
Name: irq_vector_dispatch

Overview:
- Sits downstream of the 9-channel priority interrupt encoder.
- Takes the encoded winning-channel index, queues it, and issues a one-cycle one-hot acknowledge back to the requesting channel.
- Tracks the in-service channel until the handler signals end-of-interrupt (EOI).
- Decodes the encoder's output back into per-channel acknowledge and service state.

Parameters:
- NCH, 9, number of interrupt channels (valid ids 0..NCH-1).
- IDW, 4, width of the encoded channel id.
- DEPTH, 4, pending-vector FIFO depth (power of two, ≥2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  encoder presents a vector this cycle.
- req_id  in  IDW  encoded channel index.
- req_ready  out  1  dispatcher can accept a vector; equals !full.
- ack  out  NCH  one-hot acknowledge pulse to the serviced channel.
- isr_busy  out  1  a channel is in ACK or SERVICE.
- isr_id  out  IDW  id of the current in-service channel; 0 when idle.
- eoi  in  1  end-of-interrupt strobe from the handler.
- pend_cnt  out  log2(DEPTH)+1  number of queued vectors.
- pend_mask  out  NCH  bit i set while id i is queued or in service.
- err  out  1  sticky: out-of-range id or overflow attempt.
- clr_err  in  1  clears err.

Behaviour:
- Reset: synchronous with rst high. Same cycle's edge produces:
  - FIFO empty, pend_cnt=0, pend_mask=0.
  - FSM=IDLE, ack=0, isr_busy=0, isr_id=0, err=0.
  - Reset mid-service drops all queued and in-service vectors and emits no ack.
- Accept: a transfer occurs on an edge with req_valid && req_ready.
  - id ≥ NCH: vector discarded, err set.
  - pend_mask[id]=1 (duplicate): vector discarded silently; err unchanged.
  - Otherwise: id written at the FIFO tail, pend_cnt+1, pend_mask[id] set.
- Ready and overflow:
  - req_ready = (pend_cnt != DEPTH). It is combinational from registered count only, and does not look ahead to a same-cycle pop.
  - req_valid while !req_ready sets err; the vector is lost.
- FSM:
  - IDLE: if FIFO non-empty, pop the head, load isr_id, go to ACK. Else stay.
  - ACK: held for exactly one cycle. ack[isr_id]=1 only in this state. Next state is SERVICE. eoi is ignored in ACK.
  - SERVICE: wait for eoi. On eoi, clear pend_mask[isr_id] and go to IDLE. isr_id stays valid until the IDLE edge; it is 0 in IDLE.
  - isr_busy = (state != IDLE).
- Latency:
  - Vector accepted at edge t with FIFO empty and FSM IDLE: pop at edge t+1, ack high during cycle t+1..t+2, SERVICE from edge t+2.
  - After eoi sampled at edge e with FIFO non-empty: IDLE at e, pop at e+1, next ack during e+1..e+2. One idle cycle between services is required.
- pend_cnt: on the pop edge it decrements. Simultaneous push and pop leaves it unchanged. pend_mask bit stays set through ACK and SERVICE.
- Same-cycle events:
  - Same-cycle accept of id X and eoi for X: the eoi clear wins for the mask and the push is treated as a duplicate (dropped).
  - Subsequent requests for X are accepted normally.
- FIFO pointers: log2(DEPTH) bits, wrap modulo DEPTH. Ordering is strictly FIFO, with no re-prioritisation; priority was already resolved upstream.
- err: set has priority over clr_err in the same cycle.
- Registering: all outputs registered except req_ready.

Test Plan:
- rst held 2 cycles during SERVICE of id 5 with 3 queued → next cycle: ack=0, isr_busy=0, pend_cnt=0, pend_mask=0, err=0.
- Single vector id=3 at edge t → ack=9'b000001000 during cycle t+1 only; isr_id=3; isr_busy until eoi; pend_mask[3] clears on eoi edge.
- Push ids 2,7,0,8 back-to-back, then eoi after each service → acks in order 2,7,0,8; pend_cnt 4→3→2→1→0; req_ready low while pend_cnt=4.
- Fifth push (id 4) while full → not stored, err=1; clr_err with no new error → err=0.
- Push id 6 twice while 6 pending → second dropped, pend_cnt unchanged, err=0. Push id 12 → dropped, err=1.
- eoi strobed during ACK of id 1 → ignored; FSM stays in SERVICE until a later eoi; no second ack for id 1.
